// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and helpers for the SPI framing controllers
//
// Purpose: the controller state encoding and a width helper. Both the
//          master and slave framing controllers use them.
// Ports:   none (package)

package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } spi_ctrl_state_t;

  // Width needed to index n items. It never returns less than 1, so that a
  // single-item select still has a real port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_sck_edge_det.sv
// rtl/spi_sck_edge_det.sv - registered trailing-edge detector for sck
//
// Purpose: produces a one-cycle pulse for every transition of sck back to its
//          idle level POL. The pulse is registered, so it appears one clk after
//          the edge is first seen in sck_q.
// Ports:   i_clk   system clock, posedge
//          i_rst   synchronous active-high reset
//          i_sck   serial clock, synchronous to i_clk
//          o_trail one-cycle trailing-edge pulse

module spi_sck_edge_det #(
  parameter logic POL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sck,
  output logic o_trail
);

  logic r_sck_q;
  logic r_trail;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sck_q <= POL;
      r_trail <= 1'b0;
    end else begin
      r_sck_q <= i_sck;
      r_trail <= (i_sck == POL) && (r_sck_q != POL);
    end
  end

  assign o_trail = r_trail;

endmodule

// File: rtl/spi_master_ctrl_n.sv
// rtl/spi_master_ctrl_n.sv - SPI master framing controller with N selects
//
// Purpose: frames SPI transfers. It asserts one active-low select, gates the
//          external clk_div through en_sck, counts trailing sck edges in
//          words, and applies select setup, hold and inter-frame gap times.
// Ports:   i_clk        system clock, posedge
//          i_rst        synchronous active-high reset
//          i_en         transfer request / continue level
//          i_ss_sel     slave index
//          i_sck        serial clock from clk_div
//          o_ss         active-low selects, at most one low
//          o_en_sck     clk_div enable
//          o_busy       high in every state but IDLE
//          o_word_done  one-cycle pulse per completed word

module spi_master_ctrl_n
  import spi_pkg::*;
#(
  parameter int   WORD_BITS  = 8,
  parameter int   N_SS       = 1,
  parameter logic POL        = 1'b1,
  parameter int   SETUP_CLKS = 2,
  parameter int   HOLD_CLKS  = 2,
  parameter int   GAP_CLKS   = 4,
  localparam int  SEL_W      = sel_width(N_SS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [SEL_W-1:0]  i_ss_sel,
  input  logic              i_sck,
  output logic [N_SS-1:0]   o_ss,
  output logic              o_en_sck,
  output logic              o_busy,
  output logic              o_word_done
);

  localparam int CNT_MAX0 = (SETUP_CLKS > HOLD_CLKS) ? SETUP_CLKS : HOLD_CLKS;
  localparam int CNT_MAX  = (CNT_MAX0 > GAP_CLKS) ? CNT_MAX0 : GAP_CLKS;
  localparam int CNT_W    = sel_width(CNT_MAX);
  localparam int BIT_W    = $clog2(WORD_BITS + 1);

  localparam logic [SEL_W:0]   N_SS_W    = (SEL_W + 1)'(N_SS);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CLKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CLKS - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CLKS - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_BITS - 1);

  spi_ctrl_state_t    r_state;
  logic [SEL_W-1:0]   r_sel_q;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [N_SS-1:0]    r_ss;
  logic               r_en_sck;
  logic               r_busy;
  logic               r_word_done;

  logic               w_trail;
  logic               w_sel_ok;
  logic               w_cnt_zero;
  logic [N_SS-1:0]    w_ss_decode;

  spi_sck_edge_det #(
    .POL (POL)
  ) u_edge (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_sck   (i_sck),
    .o_trail (w_trail)
  );

  // Out-of-range indices are rejected, so no select is ever asserted for them.
  assign w_sel_ok    = ({1'b0, i_ss_sel} < N_SS_W);
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_ss_decode = ~(N_SS'(1) << i_ss_sel);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_sel_q     <= '0;
      r_cnt       <= '0;
      r_bit_cnt   <= '0;
      r_ss        <= '1;
      r_en_sck    <= 1'b0;
      r_busy      <= 1'b0;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_en && w_sel_ok) begin
            r_sel_q <= i_ss_sel;
            r_ss    <= w_ss_decode;
            r_cnt   <= SETUP_LD;
            r_busy  <= 1'b1;
            r_state <= SETUP;
          end
        end

        SETUP: begin
          if (w_cnt_zero) begin
            r_en_sck  <= 1'b1;
            r_bit_cnt <= '0;
            r_state   <= XFER;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        XFER: begin
          if (w_trail) begin
            // The increment and the word-complete decision share this edge,
            // so word_done and the en_sck fall appear together.
            if (r_bit_cnt == LAST_BIT) begin
              r_word_done <= 1'b1;
              r_bit_cnt   <= '0;
              if (!(i_en && (i_ss_sel == r_sel_q))) begin
                r_en_sck <= 1'b0;
                r_cnt    <= HOLD_LD;
                r_state  <= HOLD;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end
        end

        HOLD: begin
          if (w_cnt_zero) begin
            r_ss    <= '1;
            r_cnt   <= GAP_LD;
            r_state <= GAP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        GAP: begin
          if (w_cnt_zero) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        default: begin
          r_ss     <= '1;
          r_en_sck <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign o_ss        = r_ss;
  assign o_en_sck    = r_en_sck;
  assign o_busy      = r_busy;
  assign o_word_done = r_word_done;

endmodule

// File: tb/tb_spi_master_ctrl_n.sv
// tb/tb_spi_master_ctrl_n.sv - directed self-checking bench for spi_master_ctrl_n

module tb_spi_master_ctrl_n;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A: 4 selects, POL=1, 8-bit words
  logic       en_a = 1'b0;
  logic [1:0] sel_a = 2'd0;
  logic       sck_a = 1'b1;
  logic       div_a = 1'b0;
  logic [3:0] ss_a;
  logic       en_sck_a, busy_a, wd_a;

  // Instance B: 3 selects, POL=0, 12-bit words
  logic       en_b = 1'b0;
  logic [1:0] sel_b = 2'd0;
  logic       sck_b = 1'b0;
  logic       div_b = 1'b0;
  logic [2:0] ss_b;
  logic       en_sck_b, busy_b, wd_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_master_ctrl_n #(
    .WORD_BITS(8), .N_SS(4), .POL(1'b1),
    .SETUP_CLKS(2), .HOLD_CLKS(2), .GAP_CLKS(4)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_en(en_a), .i_ss_sel(sel_a), .i_sck(sck_a),
    .o_ss(ss_a), .o_en_sck(en_sck_a), .o_busy(busy_a), .o_word_done(wd_a)
  );

  spi_master_ctrl_n #(
    .WORD_BITS(12), .N_SS(3), .POL(1'b0),
    .SETUP_CLKS(2), .HOLD_CLKS(2), .GAP_CLKS(4)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_en(en_b), .i_ss_sel(sel_b), .i_sck(sck_b),
    .o_ss(ss_b), .o_en_sck(en_sck_b), .o_busy(busy_b), .o_word_done(wd_b)
  );

  // clk_div models: held at POL while disabled, half period of 2 clk cycles.
  always @(posedge clk) begin
    if (rst || !en_sck_a) begin
      sck_a <= 1'b1;
      div_a <= 1'b0;
    end else if (div_a) begin
      sck_a <= ~sck_a;
      div_a <= 1'b0;
    end else begin
      div_a <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst || !en_sck_b) begin
      sck_b <= 1'b0;
      div_b <= 1'b0;
    end else if (div_b) begin
      sck_b <= ~sck_b;
      div_b <= 1'b0;
    end else begin
      div_b <= 1'b1;
    end
  end

  task automatic wait_idle_a(input string name);
    int t;
    t = 0;
    while (busy_a !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_timeout busy=%b expected 0", name, busy_a);
    end
  endtask

  task automatic wait_en_sck_a(input string name);
    int t;
    t = 0;
    while (en_sck_a !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (en_sck_a !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_en_sck_timeout en_sck=%b expected 1", name, en_sck_a);
    end
  endtask

  task automatic test_reset;
    int bad;
    // initial reset state
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (ss_a !== 4'b1111 || en_sck_a !== 1'b0 || busy_a !== 1'b0 || wd_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init_a ss=%b en_sck=%b busy=%b wd=%b expected 1111/0/0/0",
               ss_a, en_sck_a, busy_a, wd_a);
    end
    n_tests++;
    if (ss_b !== 3'b111 || en_sck_b !== 1'b0 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init_b ss=%b en_sck=%b busy=%b expected 111/0/0",
               ss_b, en_sck_b, busy_b);
    end
    rst = 1'b0;

    // reset in the middle of a transfer on select 2
    @(negedge clk);
    sel_a = 2'd2;
    en_a  = 1'b1;
    wait_en_sck_a("reset_mid");
    repeat (5) @(negedge clk);
    n_tests++;
    if (ss_a !== 4'b1011) begin
      n_fail++;
      $display("FAIL reset_mid_ss ss=%b expected 1011", ss_a);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ss_a !== 4'b1111 || en_sck_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_clear ss=%b en_sck=%b busy=%b expected 1111/0/0",
               ss_a, en_sck_a, busy_a);
    end
    @(negedge clk);
    rst  = 1'b0;
    en_a = 1'b0;
    bad  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ss_a !== 4'b1111 || en_sck_a !== 1'b0 || busy_a !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_quiet cycles_active=%0d expected 0", bad);
    end
  endtask

  task automatic test_single_word;
    int  edges, wds;
    logic prev;
    bit  done;
    @(negedge clk);
    sel_a = 2'd1;
    en_a  = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    n_tests++;
    if (ss_a !== 4'b1101 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL single_select ss=%b busy=%b expected 1101/1", ss_a, busy_a);
    end
    @(negedge clk);
    n_tests++;
    if (en_sck_a !== 1'b0) begin
      n_fail++;
      $display("FAIL single_setup_early en_sck=%b expected 0", en_sck_a);
    end
    @(negedge clk);
    n_tests++;
    if (en_sck_a !== 1'b1) begin
      n_fail++;
      $display("FAIL single_setup_rise en_sck=%b expected 1", en_sck_a);
    end
    edges = 0;
    wds   = 0;
    done  = 0;
    prev  = sck_a;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (en_sck_a && sck_a && !prev) edges++;
      if (wd_a) wds++;
      if (!en_sck_a) begin
        done = 1;
        n_tests++;
        if (wd_a !== 1'b1) begin
          n_fail++;
          $display("FAIL single_wd_with_fall wd=%b expected 1", wd_a);
        end
      end
      prev = sck_a;
    end
    n_tests++;
    if (!done || edges != 8 || wds != 1) begin
      n_fail++;
      $display("FAIL single_word done=%0d edges=%0d wds=%0d expected 1/8/1", done, edges, wds);
    end
    @(negedge clk);
    n_tests++;
    if (ss_a !== 4'b1101) begin
      n_fail++;
      $display("FAIL single_hold ss=%b expected 1101", ss_a);
    end
    @(negedge clk);
    n_tests++;
    if (ss_a !== 4'b1111) begin
      n_fail++;
      $display("FAIL single_release ss=%b expected 1111", ss_a);
    end
    wait_idle_a("single");
  endtask

  task automatic test_multi_word;
    int  edges, wds;
    int  wd_edges[3];
    logic prev;
    bit  done;
    @(negedge clk);
    sel_a = 2'd0;
    en_a  = 1'b1;
    wait_en_sck_a("multi");
    edges = 0;
    wds   = 0;
    done  = 0;
    prev  = sck_a;
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge clk);
      if (en_sck_a && sck_a && !prev) edges++;
      if (edges == 20) en_a = 1'b0;
      if (wd_a) begin
        if (wds < 3) wd_edges[wds] = edges;
        wds++;
      end
      if (!en_sck_a) done = 1;
      prev = sck_a;
    end
    n_tests++;
    if (!done || edges != 24 || wds != 3) begin
      n_fail++;
      $display("FAIL multi_word done=%0d edges=%0d wds=%0d expected 1/24/3", done, edges, wds);
    end
    n_tests++;
    if (wd_edges[0] != 8 || wd_edges[1] != 16 || wd_edges[2] != 24) begin
      n_fail++;
      $display("FAIL multi_wd_positions got %0d,%0d,%0d expected 8,16,24",
               wd_edges[0], wd_edges[1], wd_edges[2]);
    end
    wait_idle_a("multi");
  endtask

  task automatic test_gap_reselect;
    int  edges, ones, t;
    logic prev;
    bit  done;
    @(negedge clk);
    sel_a = 2'd0;
    en_a  = 1'b1;
    wait_en_sck_a("gap");
    edges = 0;
    done  = 0;
    prev  = sck_a;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (en_sck_a && sck_a && !prev) edges++;
      if (edges == 4) sel_a = 2'd3;
      if (!en_sck_a) done = 1;
      prev = sck_a;
    end
    n_tests++;
    if (!done || edges != 8 || ss_a !== 4'b1110) begin
      n_fail++;
      $display("FAIL gap_first_word done=%0d edges=%0d ss=%b expected 1/8/1110", done, edges, ss_a);
    end
    t = 0;
    while (ss_a === 4'b1110 && t < 50) begin
      @(negedge clk);
      t++;
    end
    ones = 0;
    while (ss_a === 4'b1111 && t < 100) begin
      ones++;
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (ones < 5) begin
      n_fail++;
      $display("FAIL gap_length high_cycles=%0d expected >=5", ones);
    end
    n_tests++;
    if (ss_a !== 4'b0111) begin
      n_fail++;
      $display("FAIL gap_reselect ss=%b expected 0111", ss_a);
    end
    en_a = 1'b0;
    wait_idle_a("gap");
  endtask

  task automatic test_mode;
    int  edges, wds;
    logic prev;
    bit  done;
    @(negedge clk);
    sel_b = 2'd1;
    en_b  = 1'b1;
    @(negedge clk);
    en_b = 1'b0;
    n_tests++;
    if (ss_b !== 3'b101 || busy_b !== 1'b1) begin
      n_fail++;
      $display("FAIL mode_select ss=%b busy=%b expected 101/1", ss_b, busy_b);
    end
    edges = 0;
    wds   = 0;
    done  = 0;
    prev  = sck_b;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (en_sck_b && !sck_b && prev) edges++;
      if (wd_b) wds++;
      if (t > 3 && !en_sck_b) done = 1;
      prev = sck_b;
    end
    n_tests++;
    if (!done || edges != 12 || wds != 1) begin
      n_fail++;
      $display("FAIL mode_word done=%0d edges=%0d wds=%0d expected 1/12/1", done, edges, wds);
    end
    repeat (10) @(negedge clk);
    n_tests++;
    if (ss_b !== 3'b111 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL mode_end ss=%b busy=%b expected 111/0", ss_b, busy_b);
    end
  endtask

  task automatic test_invalid_select;
    int bad;
    @(negedge clk);
    sel_b = 2'd3;
    en_b  = 1'b1;
    bad   = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ss_b !== 3'b111 || busy_b !== 1'b0 || en_sck_b !== 1'b0) bad++;
    end
    en_b = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL invalid_select active_cycles=%0d expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_multi_word();
    test_gap_reselect();
    test_mode();
    test_invalid_select();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl_n.md
# spi_master_ctrl_n

Parametrised SPI master framing controller. Given a transfer request and a slave index, it drives one of N active-low slave selects and gates the external `clk_div` serial clock through `en_sck`. It counts completed bits in words of `WORD_BITS` and applies programmable select setup, hold and inter-frame gap times. It sits between the SPI shift datapath/host logic and the `clk_div` instance that produces `sck`.

## Interface
- `WORD_BITS`, 8: bits per word; frames are whole multiples of this; ≥1.
- `N_SS`, 1: number of slave-select lines; ≥1.
- `POL`, 1'b1: `sck` idle level; must match the `clk_div` `POL`.
- `SETUP_CLKS`, 2: clk cycles from select assertion to `en_sck` rise; ≥1.
- `HOLD_CLKS`, 2: clk cycles from `en_sck` fall to select deassertion; ≥1.
- `GAP_CLKS`, 4: minimum clk cycles with all selects high between frames; ≥1.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  transfer request/continue, sampled on posedge `clk`.
- `ss_sel`  in  SEL_W  slave index, where SEL_W = (N_SS>1) ? $clog2(N_SS) : 1.
- `sck`  in  1  serial clock from `clk_div`; synchronous to `clk`; held at `POL` while `en_sck`=0.
- `ss`  out  N_SS  active-low selects; at most one bit low at any time.
- `en_sck`  out  1  enables `clk_div`; its inverse is ORed into `clk_div` reset.
- `busy`  out  1  high in every state except IDLE.
- `word_done`  out  1  one-cycle pulse at each completed word.

## Operation
- Bit completion is the trailing `sck` edge, i.e. the transition back to `POL`: posedge when `POL`=1, negedge when `POL`=0.
  - Detection: `sck_q` registered each clk; edge = (`sck`==`POL`) && (`sck_q`!=`POL`).
- IDLE:
  - `en`=1 and `ss_sel`<`N_SS` → latch `sel_q`=`ss_sel`, drive `ss[sel_q]`=0, load `cnt`=`SETUP_CLKS`-1, go to SETUP.
  - `ss_sel`≥`N_SS` → request ignored; stay in IDLE.
- SETUP: decrement `cnt`; at 0 → `en_sck`=1, `bit_cnt`=0, go to XFER.
- XFER: each trailing edge increments `bit_cnt` (width $clog2(`WORD_BITS`+1)). When `bit_cnt` reaches `WORD_BITS`:
  - `word_done` pulses.
  - `en`=1 and `ss_sel`==`sel_q` → `bit_cnt`=0, `en_sck` stays 1, next word follows with no gap.
  - Otherwise → `en_sck`=0, `cnt`=`HOLD_CLKS`-1, go to HOLD.
- HOLD: `ss[sel_q]` stays low; at `cnt`=0 → `ss`=all ones, `cnt`=`GAP_CLKS`-1, go to GAP.
- GAP: all selects high; at `cnt`=0 → IDLE. `en` is ignored in GAP.
- `en` is a level, not an edge. A 1-cycle pulse in IDLE yields exactly one word. `en` deasserted mid-word does not abort; the current word always completes.
- A changed `ss_sel` during a frame ends that frame at the word boundary. The new slave is served after GAP if `en` is still high.
- `rst` in any state:
  - Next posedge gives IDLE, `ss`=all ones, `en_sck`=0, `busy`=0, `word_done`=0, counters 0, `sck_q`=`POL`.
  - No hold or gap is applied.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- `en` sampled high in IDLE at edge k → `ss` low and `busy` high after edge k.
- `en_sck` rises after edge k+`SETUP_CLKS`.
- Trailing `sck` edge occurs before clk edge m → counted at edge m+1.
  - On the last bit, `word_done` and `en_sck` fall are both visible after edge m+1.
- `ss` rises `HOLD_CLKS` cycles after `en_sck` falls.
- Earliest next `ss` fall is `GAP_CLKS`+1 cycles after `ss` rises.
- Reset outputs: `ss`='1, `en_sck`=0, `busy`=0, `word_done`=0.

## Structure
- Package `spi_pkg`:
  - `spi_ctrl_state_t` enum {IDLE, SETUP, XFER, HOLD, GAP}.
  - Function `sel_width(n)`.
- Sub-module `spi_sck_edge_det #(POL)`:
  - Inputs `sck`, `rst`, `clk`; output `trail` pulse.
  - Reused by the slave-side controller.
- One shared down-counter `cnt` covers SETUP, HOLD and GAP, sized to max(`SETUP_CLKS`,`HOLD_CLKS`,`GAP_CLKS`).

## Test plan
- Reset: hold `rst` 2 cycles mid-XFER (`N_SS`=4, `sel`=2) → next posedge `ss`=4'b1111, `en_sck`=0, `busy`=0, and they stay so for 20 cycles with `en`=0.
- Single word: `POL`=1, 1-cycle `en` pulse, `ss_sel`=1 → `ss`=4'b1101.
  - `en_sck` rises exactly 2 cycles later.
  - After 8 `sck` posedges: one `word_done`, `en_sck`=0.
  - `ss`=4'b1111 2 cycles later.
- Multi-word: `en` held, `WORD_BITS`=8 → 3 `word_done` pulses at 24 trailing edges; `en_sck` continuous throughout; `en` dropped after the 20th edge → frame ends after edge 24.
- Gap/reselect: `en` held, `ss_sel` 0→3 after the 4th bit → word completes on `ss[0]`; all selects high for ≥5 cycles; then `ss[3]` low.
- Mode: `POL`=0, `WORD_BITS`=12 → counting on `sck` negedges; `word_done` after the 12th.
- Invalid select: `N_SS`=3, `ss_sel`=3, `en`=1 for 10 cycles → `ss`=3'b111, `busy`=0, `en_sck`=0 throughout.
